line_writeback_buffer: RTL and testbench

//  Single-entry victim/write-back buffer for a cache line; write-side counterpart of the prefetch stream buffer.

---
 rtl/line_writeback_buffer_if.sv | 41 ++++
 rtl/line_writeback_buffer.sv | 167 ++++++++++++++++
 tb/tb_line_writeback_buffer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_writeback_buffer_if.sv
// AXI3 write-channel bundle (AW, W, B) shared by the write-back buffer and its slave.
interface axi3_wr_bus;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/line_writeback_buffer.sv
// Single-entry cache-line write-back buffer: one AXI3 INCR burst per pushed dirty line.
// Define WB_QUERY_EN to enable label lookup / forwarding of the in-flight line.
module line_writeback_buffer #(
    parameter int LINE_WIDTH = 256,
    parameter int AWID       = 2,
    localparam int BEATS       = LINE_WIDTH / 32,
    localparam int CNT_W       = $clog2(BEATS),
    localparam int PHYS_W      = 32,
    localparam int OFF_W       = $clog2(LINE_WIDTH / 8),
    localparam int LABEL_WIDTH = PHYS_W - OFF_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LABEL_WIDTH-1:0] label_i,
    input  logic [LINE_WIDTH-1:0]  data_i,
    input  logic                   push,
    output logic                   ready,
    output logic                   done,
    output logic                   err,
    input  logic [LABEL_WIDTH-1:0] query_label,
    output logic                   query_hit,
    output logic [LINE_WIDTH-1:0]  query_data,
    axi3_wr_bus.master             axi3_wr_if
);

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WAIT_AW,
        WB_SEND_W,
        WB_WAIT_B
    } wb_state_t;

    wb_state_t              state_reg, state_next;
    logic [CNT_W-1:0]       beat_cnt_reg, beat_cnt_next;
    logic [LABEL_WIDTH-1:0] label_reg;
    logic [LINE_WIDTH-1:0]  line_reg;
    logic                   pending_reg;
    logic                   done_reg;
    logic                   err_reg;

    logic                   accept;
    logic                   b_fire;
    logic                   aw_valid;
    logic                   w_valid;
    logic                   b_ready;
    logic                   last_beat;
    logic [31:0]            line_words [BEATS];
    logic                   unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_words
            assign line_words[gi] = line_reg[32*gi +: 32];
        end
    endgenerate

    assign last_beat = (beat_cnt_reg == CNT_W'(BEATS - 1));

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        accept        = 1'b0;
        b_fire        = 1'b0;
        aw_valid      = 1'b0;
        w_valid       = 1'b0;
        b_ready       = 1'b0;
        case (state_reg)
            WB_IDLE: begin
                if (push) begin
                    accept     = 1'b1;
                    state_next = WB_WAIT_AW;
                end
            end
            WB_WAIT_AW: begin
                aw_valid = 1'b1;
                if (axi3_wr_if.awready) begin
                    state_next    = WB_SEND_W;
                    beat_cnt_next = '0;
                end
            end
            WB_SEND_W: begin
                w_valid = 1'b1;
                if (axi3_wr_if.wready) begin
                    // counter wraps to zero naturally after the last beat
                    beat_cnt_next = CNT_W'(beat_cnt_reg + 1'b1);
                    if (last_beat) begin
                        state_next = WB_WAIT_B;
                    end
                end
            end
            WB_WAIT_B: begin
                b_ready = 1'b1;
                if (axi3_wr_if.bvalid) begin
                    b_fire     = 1'b1;
                    state_next = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= WB_IDLE;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            label_reg <= label_i;
            line_reg  <= data_i;
        end
    end

    // done and err land together on the cycle the buffer becomes ready again
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= b_fire;
            if (accept) begin
                pending_reg <= 1'b1;
                err_reg     <= 1'b0;
            end else if (b_fire) begin
                pending_reg <= 1'b0;
                err_reg     <= (axi3_wr_if.bresp != 2'b00);
            end
        end
    end

    assign ready = (state_reg == WB_IDLE);
    assign done  = done_reg;
    assign err   = err_reg;

    assign axi3_wr_if.awid    = 4'(AWID);
    assign axi3_wr_if.awaddr  = {label_reg, {OFF_W{1'b0}}};
    assign axi3_wr_if.awlen   = 4'(BEATS - 1);
    assign axi3_wr_if.awsize  = 3'b010;
    assign axi3_wr_if.awburst = 2'b01;
    assign axi3_wr_if.awlock  = '0;
    assign axi3_wr_if.awcache = '0;
    assign axi3_wr_if.awprot  = '0;
    assign axi3_wr_if.awvalid = aw_valid;
    assign axi3_wr_if.wid     = 4'(AWID);
    assign axi3_wr_if.wdata   = line_words[beat_cnt_reg];
    assign axi3_wr_if.wstrb   = 4'hF;
    assign axi3_wr_if.wlast   = last_beat;
    assign axi3_wr_if.wvalid  = w_valid;
    assign axi3_wr_if.bready  = b_ready;

`ifdef WB_QUERY_EN
    assign query_hit   = pending_reg && (query_label == label_reg);
    assign query_data  = line_reg;
    assign unused_bits = ^axi3_wr_if.bid;
`else
    assign query_hit   = 1'b0;
    assign query_data  = '0;
    assign unused_bits = ^{axi3_wr_if.bid, query_label, pending_reg};
`endif

endmodule

// File: tb/tb_line_writeback_buffer.sv
// Directed bench for line_writeback_buffer: bench-side AXI3 write slave with scripted handshakes.
module tb_line_writeback_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [26:0]  label_i;
    logic [255:0] data_i;
    logic         push;
    logic         ready;
    logic         done;
    logic         err;
    logic [26:0]  query_label;
    logic         query_hit;
    logic [255:0] query_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi3_wr_bus axi ();

    line_writeback_buffer #(
        .LINE_WIDTH (256),
        .AWID       (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .label_i     (label_i),
        .data_i      (data_i),
        .push        (push),
        .ready       (ready),
        .done        (done),
        .err         (err),
        .query_label (query_label),
        .query_hit   (query_hit),
        .query_data  (query_data),
        .axi3_wr_if  (axi)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Pushes one line, plays the slave, checks the burst.
    // push2_beat >= 0: stray push while that beat is presented; rst_beat >= 0: reset there.
    task automatic run_burst(input logic [26:0] lbl, input logic [31:0] base, input int aw_delay,
                             input bit w_alt, input logic [1:0] resp,
                             input int push2_beat, input int rst_beat);
        logic [255:0] line;
        logic [31:0]  beats [$];
        bit           lasts [$];
        int           cyc, aw_wait, aw_cnt, aw_bad, w_bad, w_early, ready_bad;
        bit           wtgl, fin, done_seen, done_ready, done_err;
        bit           aw_stall, w_stall;
        logic [31:0]  sv_awaddr, sv_wdata, got_awaddr;
        logic [3:0]   sv_awlen, got_awlen, got_awid;
        logic [2:0]   got_awsize;
        logic [1:0]   got_awburst;
        logic         sv_wlast, exp_hit;
        logic [255:0] exp_qd;

        for (int k = 0; k < 8; k++) line[32*k +: 32] = base + 32'(k);
`ifdef WB_QUERY_EN
        exp_hit = 1'b1;
        exp_qd  = line;
`else
        exp_hit = 1'b0;
        exp_qd  = '0;
`endif
        cyc = 0; aw_wait = 0; aw_cnt = 0; aw_bad = 0; w_bad = 0; w_early = 0; ready_bad = 0;
        wtgl = 0; fin = 0; done_seen = 0; done_ready = 0; done_err = 0;
        aw_stall = 0; w_stall = 0;
        sv_awaddr = '0; sv_wdata = '0; sv_awlen = '0; sv_wlast = 0;
        got_awaddr = '0; got_awlen = '0; got_awid = '0; got_awsize = '0; got_awburst = '0;

        label_i = lbl;
        data_i  = line;
        push    = 1'b1;
        @(negedge clk);
        push = 1'b0;
        check_eq("accept_ready", ready, 1'b0);
        check_eq("accept_err", err, 1'b0);

        while (!fin && cyc < 200) begin
            if (aw_stall && (axi.awvalid !== 1'b1 || axi.awaddr !== sv_awaddr || axi.awlen !== sv_awlen))
                aw_bad++;
            if (w_stall && (axi.wvalid !== 1'b1 || axi.wdata !== sv_wdata || axi.wlast !== sv_wlast))
                w_bad++;
            if (axi.wvalid && aw_cnt == 0) w_early++;

            if (done === 1'b1) begin
                done_seen  = 1;
                done_ready = ready;
                done_err   = err;
                fin        = 1;
                #1;
                check_eq("query_hit_after_done", query_hit, 1'b0);
            end else if (ready === 1'b1) begin
                ready_bad++;
            end

            if (!fin && rst_beat >= 0 && axi.wvalid && beats.size() == rst_beat) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                rst_n = 1'b0;
                @(negedge clk);
                check_eq("rst_wvalid", axi.wvalid, 1'b0);
                check_eq("rst_awvalid", axi.awvalid, 1'b0);
                check_eq("rst_bready", axi.bready, 1'b0);
                check_eq("rst_ready", ready, 1'b1);
                check_eq("rst_done", done, 1'b0);
                check_eq("rst_err", err, 1'b0);
                check_eq("rst_beats_before", beats.size(), 3);
                rst_n = 1'b1;
                $display("[TB] burst label=%h aborted by reset after %0d beats", lbl, beats.size());
                return;
            end

            if (fin) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                push = 1'b0;
            end else begin
                axi.awready = axi.awvalid && (aw_wait >= aw_delay);
                if (axi.awvalid) aw_wait++;
                aw_stall  = axi.awvalid && !axi.awready;
                sv_awaddr = axi.awaddr;
                sv_awlen  = axi.awlen;
                if (axi.awvalid && axi.awready) begin
                    aw_cnt++;
                    got_awaddr  = axi.awaddr;
                    got_awlen   = axi.awlen;
                    got_awsize  = axi.awsize;
                    got_awburst = axi.awburst;
                    got_awid    = axi.awid;
                end

                push = (push2_beat >= 0) && axi.wvalid && (beats.size() == push2_beat);
                if (push) begin
                    label_i = lbl ^ 27'h1;
                    data_i  = ~line;
                end

                axi.wready = w_alt ? !wtgl : 1'b1;
                if (axi.wvalid) wtgl = !wtgl;
                w_stall  = axi.wvalid && !axi.wready;
                sv_wdata = axi.wdata;
                sv_wlast = axi.wlast;
                if (axi.wvalid && axi.wready) begin
                    beats.push_back(axi.wdata);
                    lasts.push_back(axi.wlast);
                end

                axi.bvalid = axi.bready;
                axi.bresp  = resp;
                if (axi.bready) begin
                    query_label = lbl;
                    #1;
                    check_eq("query_hit_wait_b", query_hit, exp_hit);
                    check_eq("query_data_wait_b", query_data, exp_qd);
                end
            end
            @(negedge clk);
            cyc++;
        end

        check_eq("done_seen", done_seen, 1'b1);
        check_eq("done_pulse_end", done, 1'b0);
        check_eq("ready_with_done", done_ready, 1'b1);
        check_eq("err_with_done", done_err, (resp != 2'b00));
        check_eq("aw_count", aw_cnt, 1);
        check_eq("awaddr", got_awaddr, {lbl, 5'b00000});
        check_eq("awlen", got_awlen, 4'd7);
        check_eq("awsize", got_awsize, 3'd2);
        check_eq("awburst", got_awburst, 2'd1);
        check_eq("awid", got_awid, 4'd2);
        check_eq("aw_stable", aw_bad, 0);
        check_eq("w_stable", w_bad, 0);
        check_eq("w_before_aw", w_early, 0);
        check_eq("ready_low_busy", ready_bad, 0);
        check_eq("beat_count", beats.size(), 8);
        for (int k = 0; k < beats.size() && k < 8; k++) begin
            check_eq($sformatf("wdata%0d", k), beats[k], base + 32'(k));
            check_eq($sformatf("wlast%0d", k), lasts[k], (k == 7));
        end
        $display("[TB] burst label=%h addr=%h beats=%0d err=%0b", lbl, got_awaddr, beats.size(), done_err);
    endtask

    initial begin
        rst_n       = 1'b0;
        push        = 1'b0;
        label_i     = '0;
        data_i      = '0;
        query_label = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", ready, 1'b1);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_err", err, 1'b0);
        check_eq("reset_awvalid", axi.awvalid, 1'b0);
        check_eq("reset_wvalid", axi.wvalid, 1'b0);
        check_eq("reset_bready", axi.bready, 1'b0);
        check_eq("reset_query_hit", query_hit, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic burst, always-ready slave
        run_burst(27'h0123456, 32'h000000A0, 0, 1'b0, 2'b00, -1, -1);
        // late awready, alternating wready
        run_burst(27'h1ABCDEF, 32'hB0000000, 5, 1'b1, 2'b00, -1, -1);
        // error response, err must stick while idle
        run_burst(27'h0000ABC, 32'h000000C0, 0, 1'b0, 2'b10, -1, -1);
        repeat (4) @(negedge clk);
        check_eq("err_sticky", err, 1'b1);
        check_eq("idle_ready", ready, 1'b1);
        // stray push mid-burst ignored; this accept also clears err
        run_burst(27'h0000001, 32'h000000D0, 0, 1'b0, 2'b00, 2, -1);
        // reset during beat 3
        run_burst(27'h0000055, 32'h000000E0, 0, 1'b0, 2'b00, -1, 3);
        // clean burst after reset restarts at word 0
        run_burst(27'h0123456, 32'h000000F0, 0, 1'b0, 2'b00, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
